// File: rtl/puf_vote_ctrl.sv
// rtl/puf_vote_ctrl.sv - arbiter PUF controller: repeated races per challenge, per-bit majority vote
module puf_vote_ctrl #(
    parameter int N      = 128,
    parameter int M      = 128,
    parameter int NEVAL  = 5,
    parameter int SETTLE = 4,
    parameter int RELAX  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [N-1:0] challenge,
    output logic [N-1:0] chal_out,
    output logic         race,
    input  logic [M-1:0] arb_resp,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [M-1:0] response,
    output logic [M-1:0] unstable
);

    localparam int CW   = $clog2(NEVAL + 1);
    localparam int TMAX = (SETTLE > RELAX) ? SETTLE : RELAX;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RELAX,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [CW-1:0] evals;
    logic [CW-1:0] votes [M];
    logic          last_settle;
    logic          done_entry;

    always_comb begin
        state_nxt   = state;
        last_settle = 1'b0;
        case (state)
            ST_IDLE: begin
                if (chal_valid) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (timer == TW'(SETTLE - 1)) begin
                    last_settle = 1'b1;
                    state_nxt   = ST_RELAX;
                end
            end
            ST_RELAX: begin
                if (timer == TW'(RELAX - 1))
                    state_nxt = (evals < CW'(NEVAL)) ? ST_SETTLE : ST_DONE;
            end
            ST_DONE: begin
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign done_entry = (state == ST_RELAX) && (state_nxt == ST_DONE);
    assign chal_ready = (state == ST_IDLE);
    assign resp_valid = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            evals    <= '0;
            race     <= 1'b0;
            chal_out <= '0;
            response <= '0;
            unstable <= '0;
            for (int i = 0; i < M; i++) votes[i] <= '0;
        end else begin
            state <= state_nxt;
            // race is a flop decoded from the next state so the arbiter launch never glitches
            race  <= (state_nxt == ST_SETTLE);
            if (state_nxt != state)
                timer <= '0;
            else if (state == ST_SETTLE || state == ST_RELAX)
                timer <= timer + TW'(1);

            if (state == ST_IDLE && chal_valid) begin
                chal_out <= challenge;
                evals    <= '0;
                for (int i = 0; i < M; i++) votes[i] <= '0;
            end

            if (last_settle) begin
                evals <= evals + CW'(1);
                for (int i = 0; i < M; i++) votes[i] <= votes[i] + CW'(arb_resp[i]);
            end

            if (done_entry) begin
                for (int i = 0; i < M; i++) begin
                    response[i] <= (votes[i] > CW'(NEVAL / 2));
                    unstable[i] <= (votes[i] != '0) && (votes[i] != CW'(NEVAL));
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_vote_ctrl.sv
// tb/tb_puf_vote_ctrl.sv - directed self-checking bench for puf_vote_ctrl
module tb_puf_vote_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       chal_valid;
    logic       chal_ready;
    logic [7:0] challenge;
    logic [7:0] chal_out;
    logic       race;
    logic [3:0] arb_resp;
    logic       resp_valid;
    logic       resp_ready;
    logic [3:0] response;
    logic [3:0] unstable;

    int passed = 0;
    int total  = 0;

    puf_vote_ctrl #(.N(8), .M(4), .NEVAL(3), .SETTLE(2), .RELAX(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .chal_valid (chal_valid),
        .chal_ready (chal_ready),
        .challenge  (challenge),
        .chal_out   (chal_out),
        .race       (race),
        .arb_resp   (arb_resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .response   (response),
        .unstable   (unstable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        rst        = 1'b1;
        chal_valid = 1'b0;
        challenge  = 8'h00;
        arb_resp   = 4'h0;
        resp_ready = 1'b0;
        tick();
        tick();

        chk("rst_chal_ready", chal_ready, 1);
        chk("rst_race",       race,       0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_response",   response,   0);
        chk("rst_unstable",   unstable,   0);
        chk("rst_chal_out",   chal_out,   0);

        // constant 1010 samples: race pattern, latency, unanimous vote
        rst        = 1'b0;
        chal_valid = 1'b1;
        challenge  = 8'hA5;
        arb_resp   = 4'b1010;
        tick();
        chal_valid = 1'b0;
        chk("t1_chal_ready_busy", chal_ready, 0);
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("t1_race_k%0d", k), race,
                (k == 1 || k == 2 || k == 4 || k == 5 || k == 7 || k == 8) ? 1 : 0);
            chk($sformatf("t1_resp_valid_k%0d", k), resp_valid, (k == 10) ? 1 : 0);
            chk($sformatf("t1_chal_out_k%0d", k), chal_out, 8'hA5);
            if (k < 10) tick();
        end
        chk("t1_response", response, 4'b1010);
        chk("t1_unstable", unstable, 4'b0000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t1_idle_ready",    chal_ready, 1);
        chk("t1_idle_valid",    resp_valid, 0);
        chk("t1_held_response", response,   4'b1010);

        // differing samples on the last SETTLE cycles only; other cycles drive 0
        chal_valid = 1'b1;
        challenge  = 8'h11;
        arb_resp   = 4'h0;
        tick();
        chal_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            arb_resp = (k == 2) ? 4'b1100 : (k == 5) ? 4'b1010 : (k == 8) ? 4'b1001 : 4'b0000;
            tick();
        end
        arb_resp = 4'h0;
        chk("t2_resp_valid", resp_valid, 1);
        chk("t2_response",   response,   4'b1000);
        chk("t2_unstable",   unstable,   4'b0111);

        // backpressure with a competing challenge offered
        chal_valid = 1'b1;
        challenge  = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_resp_valid_%0d", k), resp_valid, 1);
            chk($sformatf("t3_response_%0d", k),   response,   4'b1000);
            chk($sformatf("t3_unstable_%0d", k),   unstable,   4'b0111);
            chk($sformatf("t3_chal_out_%0d", k),   chal_out,   8'h11);
            chk($sformatf("t3_chal_ready_%0d", k), chal_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t3_idle_ready",    chal_ready, 1);
        chk("t3_not_captured",  chal_out,   8'h11);
        arb_resp = 4'b1111;
        tick();
        chal_valid = 1'b0;
        chk("t3_captured", chal_out, 8'h3C);
        chk("t3_race",     race,     1);
        for (int k = 2; k <= 10; k++) tick();
        chk("t3_resp_valid", resp_valid, 1);
        chk("t3_response",   response,   4'b1111);
        chk("t3_unstable",   unstable,   4'b0000);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // reset during the second SETTLE after one vote of 1111 is counted
        chal_valid = 1'b1;
        challenge  = 8'h77;
        arb_resp   = 4'b1111;
        tick();
        chal_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("t4_second_settle", race, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_race",       race,       0);
        chk("t4_rst_chal_ready", chal_ready, 1);
        chk("t4_rst_resp_valid", resp_valid, 0);
        chk("t4_rst_chal_out",   chal_out,   0);
        chk("t4_rst_response",   response,   0);
        chal_valid = 1'b1;
        challenge  = 8'h5A;
        arb_resp   = 4'b0101;
        tick();
        chal_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("t4_no_valid_k%0d", k), resp_valid, 0);
            tick();
        end
        chk("t4_resp_valid", resp_valid, 1);
        chk("t4_response",   response,   4'b0101);
        chk("t4_unstable",   unstable,   4'b0000);
        chk("t4_chal_out",   chal_out,   8'h5A);

        // streaming: both handshakes held high, one challenge every 11 cycles
        resp_ready = 1'b1;
        chal_valid = 1'b1;
        tick();
        for (int j = 0; j < 33; j++) begin
            chk($sformatf("t5_chal_ready_%0d", j), chal_ready, (j % 11 == 0) ? 1 : 0);
            chk($sformatf("t5_resp_valid_%0d", j), resp_valid, (j % 11 == 10) ? 1 : 0);
            tick();
        end
        chal_valid = 1'b0;
        resp_ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
